// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex 8N1 UART with a 16x oversampling baud tick,
// an RX FIFO with first-word fall-through and a TX FIFO feeding the transmitter.
module uart_fifo_core #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 14,
    parameter int DVSR_W  = 4,
    parameter int FIFO_W  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_fifo_flush_enable,
    input  logic            rd_uart,
    input  logic            wr_uart,
    input  logic            rx,
    input  logic [DBIT-1:0] w_data,
    output logic            tx_full,
    output logic            rx_empty,
    output logic            tx,
    output logic [DBIT-1:0] r_data
);
    localparam int SW = $clog2(SB_TICK > 16 ? SB_TICK : 16);
    localparam int NW = $clog2(DBIT);
    localparam logic [DVSR_W-1:0] B_LAST = DVSR_W'(DVSR - 1);
    localparam logic [SW-1:0] S_MID  = SW'(7);
    localparam logic [SW-1:0] S_BIT  = SW'(15);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [DVSR_W-1:0] b_cnt;
    logic              tick;
    always_ff @(posedge clk or negedge reset)
        if (!reset) b_cnt <= '0;
        else        b_cnt <= tick ? '0 : b_cnt + 1'b1;
    assign tick = (b_cnt == B_LAST);

    logic [1:0] rx_sync;
    logic       rx_s;
    always_ff @(posedge clk or negedge reset)
        if (!reset) rx_sync <= 2'b11;
        else        rx_sync <= {rx_sync[0], rx};
    assign rx_s = rx_sync[1];

    state_t          rx_state;
    logic [SW-1:0]   rx_cnt;
    logic [NW-1:0]   rx_n;
    logic [DBIT-1:0] rx_b;
    logic            rx_done;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_n     <= '0;
            rx_b     <= '0;
            rx_done  <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (rx_state)
                IDLE: if (!rx_s) begin
                    rx_state <= START;
                    rx_cnt   <= '0;
                end
                START: if (tick) begin
                    if (rx_cnt == S_MID) begin
                        // a start bit that is high again at mid-bit was only a glitch
                        rx_state <= rx_s ? IDLE : DATA;
                        rx_cnt   <= '0;
                        rx_n     <= '0;
                    end else rx_cnt <= rx_cnt + 1'b1;
                end
                DATA: if (tick) begin
                    if (rx_cnt == S_BIT) begin
                        rx_cnt <= '0;
                        rx_b   <= {rx_s, rx_b[DBIT-1:1]};
                        if (rx_n == N_LAST) rx_state <= STOP;
                        else                rx_n     <= rx_n + 1'b1;
                    end else rx_cnt <= rx_cnt + 1'b1;
                end
                STOP: if (tick) begin
                    if (rx_cnt == S_STOP) begin
                        rx_state <= IDLE;
                        rx_done  <= 1'b1;
                    end else rx_cnt <= rx_cnt + 1'b1;
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    logic [DBIT-1:0]   rx_mem [2**FIFO_W];
    logic [FIFO_W-1:0] rx_wp, rx_rp, rx_wp_n, rx_rp_n;
    logic              rx_full, rx_we, rx_re;
    assign rx_we   = rx_done & ~rx_full;
    assign rx_re   = rd_uart & ~rx_empty;
    assign rx_wp_n = rx_wp + 1'b1;
    assign rx_rp_n = rx_rp + 1'b1;
    assign r_data  = rx_empty ? '0 : rx_mem[rx_rp];
    always_ff @(posedge clk)
        if (rx_we) rx_mem[rx_wp] <= rx_b;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || rx_fifo_flush_enable) begin
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_full  <= 1'b0;
            rx_empty <= 1'b1;
        end else if (rx_we && !rx_re) begin
            rx_wp    <= rx_wp_n;
            rx_empty <= 1'b0;
            rx_full  <= (rx_wp_n == rx_rp);
        end else if (rx_re && !rx_we) begin
            rx_rp    <= rx_rp_n;
            rx_full  <= 1'b0;
            rx_empty <= (rx_rp_n == rx_wp);
        end else if (rx_re && rx_we) begin
            rx_wp <= rx_wp_n;
            rx_rp <= rx_rp_n;
        end
    end

    state_t            tx_state;
    logic [DBIT-1:0]   tx_mem [2**FIFO_W];
    logic [FIFO_W-1:0] tx_wp, tx_rp, tx_wp_n, tx_rp_n;
    logic              tx_empty, tx_we, tx_re;
    // a full FIFO still takes a write when the transmitter pops in the same cycle
    assign tx_re   = (tx_state == IDLE) & ~tx_empty;
    assign tx_we   = wr_uart & (~tx_full | tx_re);
    assign tx_wp_n = tx_wp + 1'b1;
    assign tx_rp_n = tx_rp + 1'b1;
    always_ff @(posedge clk)
        if (tx_we) tx_mem[tx_wp] <= w_data;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wp    <= '0;
            tx_rp    <= '0;
            tx_full  <= 1'b0;
            tx_empty <= 1'b1;
        end else if (tx_we && !tx_re) begin
            tx_wp    <= tx_wp_n;
            tx_empty <= 1'b0;
            tx_full  <= (tx_wp_n == tx_rp);
        end else if (tx_re && !tx_we) begin
            tx_rp    <= tx_rp_n;
            tx_full  <= 1'b0;
            tx_empty <= (tx_rp_n == tx_wp);
        end else if (tx_re && tx_we) begin
            tx_wp <= tx_wp_n;
            tx_rp <= tx_rp_n;
        end
    end

    logic [SW-1:0]   tx_cnt;
    logic [NW-1:0]   tx_n;
    logic [DBIT-1:0] tx_b;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_n     <= '0;
            tx_b     <= '0;
            tx       <= 1'b1;
        end else begin
            case (tx_state)
                IDLE: if (!tx_empty) begin
                    tx_state <= START;
                    tx_cnt   <= '0;
                    tx_b     <= tx_mem[tx_rp];
                    tx       <= 1'b0;
                end
                START: if (tick) begin
                    if (tx_cnt == S_BIT) begin
                        tx_state <= DATA;
                        tx_cnt   <= '0;
                        tx_n     <= '0;
                        tx       <= tx_b[0];
                    end else tx_cnt <= tx_cnt + 1'b1;
                end
                DATA: if (tick) begin
                    if (tx_cnt == S_BIT) begin
                        tx_cnt <= '0;
                        tx_b   <= tx_b >> 1;
                        if (tx_n == N_LAST) begin
                            tx_state <= STOP;
                            tx       <= 1'b1;
                        end else begin
                            tx_n <= tx_n + 1'b1;
                            tx   <= tx_b[1];
                        end
                    end else tx_cnt <= tx_cnt + 1'b1;
                end
                STOP: if (tick) begin
                    if (tx_cnt == S_STOP) tx_state <= IDLE;
                    else                  tx_cnt   <= tx_cnt + 1'b1;
                end
                default: tx_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core: scoreboard bench for the UART core, using loopback and a bit-banged rx line.
module tb_uart_fifo_core;
    localparam int DVSR = 4;
    localparam int BIT  = 16 * DVSR;

    logic       clk = 1'b0, reset = 1'b0;
    logic       rx_fifo_flush_enable = 1'b0, rd_uart = 1'b0, wr_uart = 1'b0;
    logic       rx_drv = 1'b1, loop = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic [7:0] r_data;
    logic       rx, tx, tx_full, rx_empty;
    logic [7:0] exp_q [$];
    int         checks = 0, passed = 0;

    assign rx = loop ? tx : rx_drv;
    always #5 clk = ~clk;

    uart_fifo_core #(.DVSR(DVSR), .DVSR_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .rx_fifo_flush_enable(rx_fifo_flush_enable),
        .rd_uart(rd_uart),
        .wr_uart(wr_uart),
        .rx(rx),
        .w_data(w_data),
        .tx_full(tx_full),
        .rx_empty(rx_empty),
        .tx(tx),
        .r_data(r_data)
    );

    task automatic push(input logic [7:0] b);
        w_data  = b;
        wr_uart = 1'b1;
        if (!tx_full) exp_q.push_back(b);
    endtask

    task automatic wait_tx_low(output int lat);
        lat = 0;
        while (tx !== 1'b0 && lat < 4 * BIT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            repeat (BIT) @(negedge clk);
        end
    endtask

    task automatic drain(input int n, input int budget, input string tag);
        int got, t;
        logic [7:0] e;
        got = 0;
        t = 0;
        while (got < n && t < budget) begin
            @(negedge clk);
            t++;
            rd_uart = 1'b0;
            if (!rx_empty) begin
                checks++;
                if (exp_q.size() == 0) $display("FAIL %s unexpected byte: got %h, want none", tag, r_data);
                else begin
                    e = exp_q.pop_front();
                    if (r_data !== e) $display("FAIL %s byte %0d: got %h, want %h", tag, got, r_data, e);
                    else passed++;
                end
                rd_uart = 1'b1;
                got++;
            end
        end
        @(negedge clk);
        rd_uart = 1'b0;
        checks++;
        if (got !== n) $display("FAIL %s byte count: got %0d, want %0d", tag, got, n);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (tx !== 1'b1) $display("FAIL reset tx: got %b, want 1", tx); else passed++;
        checks++; if (tx_full !== 1'b0) $display("FAIL reset tx_full: got %b, want 0", tx_full); else passed++;
        checks++; if (rx_empty !== 1'b1) $display("FAIL reset rx_empty: got %b, want 1", rx_empty); else passed++;
        checks++; if (r_data !== 8'h00) $display("FAIL reset r_data: got %h, want 00", r_data); else passed++;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        rd_uart = 1'b1;
        @(negedge clk);
        rd_uart = 1'b0;
        checks++; if (rx_empty !== 1'b1) $display("FAIL empty-read rx_empty: got %b, want 1", rx_empty); else passed++;
        checks++; if (r_data !== 8'h00) $display("FAIL empty-read r_data: got %h, want 00", r_data); else passed++;
    endtask

    task automatic test_loopback_single();
        int lat;
        logic [9:0] bits;
        bits = {1'b1, 8'h52, 1'b0};
        loop = 1'b1;
        @(negedge clk);
        push(8'h52);
        @(negedge clk);
        wr_uart = 1'b0;
        wait_tx_low(lat);
        checks++;
        if (tx !== 1'b0 || lat + 1 > DVSR + 2) $display("FAIL tx start latency: got %0d clks (tx=%b), want <= %0d", lat + 1, tx, DVSR + 2);
        else passed++;
        repeat (BIT / 2) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (tx !== bits[k]) $display("FAIL tx bit %0d: got %b, want %b", k, tx, bits[k]);
            else passed++;
            if (k < 9) repeat (BIT) @(negedge clk);
        end
        drain(1, 4 * BIT, "single");
        checks++; if (rx_empty !== 1'b1) $display("FAIL single rx_empty after pop: got %b, want 1", rx_empty); else passed++;
    endtask

    task automatic test_back_to_back();
        logic any_full;
        any_full = 1'b0;
        loop = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            any_full |= tx_full;
            push(i == 0 ? 8'h57 : 8'(8'h30 + i - 1));
        end
        @(negedge clk);
        wr_uart = 1'b0;
        any_full |= tx_full;
        checks++; if (any_full !== 1'b0) $display("FAIL burst tx_full: got %b, want 0", any_full); else passed++;
        drain(9, 12 * 9 * BIT, "burst");
    endtask

    task automatic test_tx_full();
        int lat;
        loop = 1'b1;
        @(negedge clk);
        push(8'hC0);
        @(negedge clk);
        wr_uart = 1'b0;
        wait_tx_low(lat);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i == 15) begin
                checks++; if (tx_full !== 1'b0) $display("FAIL tx_full at 15 stored: got %b, want 0", tx_full); else passed++;
            end
            if (i == 16) begin
                checks++; if (tx_full !== 1'b1) $display("FAIL tx_full at 16 stored: got %b, want 1", tx_full); else passed++;
            end
            push(8'(8'h80 + i));
        end
        @(negedge clk);
        wr_uart = 1'b0;
        checks++; if (tx_full !== 1'b1) $display("FAIL tx_full after 17th push: got %b, want 1", tx_full); else passed++;
        drain(17, 19 * 10 * BIT, "txfull");
        repeat (12 * BIT) @(negedge clk);
        checks++; if (rx_empty !== 1'b1) $display("FAIL txfull extra byte: rx_empty got %b, want 1", rx_empty); else passed++;
    endtask

    task automatic test_rx_overflow();
        loop = 1'b0;
        for (int i = 0; i < 18; i++) begin
            send_byte(8'hC3 ^ 8'(i * 7));
            if (i < 16) exp_q.push_back(8'hC3 ^ 8'(i * 7));
        end
        repeat (BIT) @(negedge clk);
        drain(16, 4 * BIT, "overflow");
        checks++; if (rx_empty !== 1'b1) $display("FAIL overflow dropped bytes: rx_empty got %b, want 1", rx_empty); else passed++;
        send_byte(8'h11);
        send_byte(8'h22);
        checks++; if (rx_empty !== 1'b0) $display("FAIL pre-flush rx_empty: got %b, want 0", rx_empty); else passed++;
        rx_fifo_flush_enable = 1'b1;
        @(negedge clk);
        rx_fifo_flush_enable = 1'b0;
        checks++; if (rx_empty !== 1'b1) $display("FAIL flush rx_empty: got %b, want 1", rx_empty); else passed++;
        checks++; if (r_data !== 8'h00) $display("FAIL flush r_data: got %h, want 00", r_data); else passed++;
        send_byte(8'hA5);
        exp_q.push_back(8'hA5);
        drain(1, 4 * BIT, "after flush");
    endtask

    task automatic test_mid_reset();
        int lat;
        loop = 1'b1;
        @(negedge clk);
        push(8'h3C);
        @(negedge clk);
        wr_uart = 1'b0;
        wait_tx_low(lat);
        repeat (BIT + BIT / 2) @(negedge clk);
        checks++; if (tx !== 1'b0) $display("FAIL midreset data bit0: got %b, want 0", tx); else passed++;
        #2 reset = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) $display("FAIL midreset tx immediate: got %b, want 1", tx); else passed++;
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (12 * BIT) @(negedge clk);
        checks++; if (rx_empty !== 1'b1) $display("FAIL midreset partial byte: rx_empty got %b, want 1", rx_empty); else passed++;
    endtask

    task automatic test_glitch();
        loop = 1'b0;
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (3 * DVSR) @(negedge clk);
        rx_drv = 1'b1;
        repeat (12 * BIT) @(negedge clk);
        checks++; if (rx_empty !== 1'b1) $display("FAIL glitch byte: rx_empty got %b, want 1", rx_empty); else passed++;
        send_byte(8'h69);
        exp_q.push_back(8'h69);
        drain(1, 4 * BIT, "post-glitch");
    endtask

    initial begin
        test_reset();
        test_loopback_single();
        test_back_to_back();
        test_tx_full();
        test_rx_overflow();
        test_mid_reset();
        test_glitch();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
